ac97_link_frame: RTL
====================

// Module: ac97_link_frame
// PURPOSE
//  AC'97 link framer. Sits directly downstream of the ac97commands sequencer and the PCM playback path.
//  Each 256-bit frame it latches one register command plus one left/right PCM sample pair.
//  It serialises them onto sdata_out with sync, deserialises the codec's sdata_in frame, and pulses ready.
//  The ready pulse is the frame strobe that advances the command sequencer and the sample source.
// PARAMETERS
//  SLOT_BITS   20   width of slots 1..12; PCM ports are SLOT_BITS wide
//  TAG_BITS    16   width of slot 0 (tag); sync is high for exactly TAG_BITS bits
//  FRAME_BITS  256  bits per frame = TAG_BITS + 12*SLOT_BITS
// PORTS
//  clock            in   1   AC'97 bit clock (12.288 MHz); sole clock, all logic on posedge
//  reset            in   1   synchronous, active-high
//  ready            out  1   one-cycle frame strobe (cycle with bit_count==255)
//  command_address  in   8   {R/W, reg index}; sampled at frame latch
//  command_data     in   16  register write data; sampled at frame latch
//  command_valid    in   1   marks slots 1/2 valid in outgoing tag
//  left_data        in   20  playback sample, left
//  left_valid       in   1   marks slot 3 valid
//  right_data       in   20  playback sample, right
//  right_valid      in   1   marks slot 4 valid
//  sync             out  1   AC'97 SYNC
//  sdata_out        out  1   AC'97 SDATA_OUT, MSB first
//  sdata_in         in   1   AC'97 SDATA_IN
//  codec_ready      out  1   input tag bit 15 of last completed frame
//  status_data      out  16  input slot 2 [19:4], last frame with input tag[13]=1
//  left_in_data     out  20  input slot 3, last frame with input tag[12]=1
//  right_in_data    out  20  input slot 4, last frame with input tag[11]=1
// BEHAVIOUR
//  - Reset: bit_count<=255; sync, sdata_out, ready, codec_ready <=0; status_data, left_in_data, right_in_data <=0.
//  - bit_count is 8 bits and wraps 255->0 unconditionally; there is no idle state.
//  - Frame latch: on every 255->0 edge, including the first edge after reset release, inputs are loaded into a 256-bit out shift register.
//  - Out frame layout, bit index n, MSB first:
//      n 0..15: tag = {1, cmd_v, cmd_v, left_v, right_v, 11'b0}
//      slot1 (n 16..35): {command_address, 12'b0}
//      slot2 (n 36..55): {command_data, 4'b0}
//      slot3 (n 56..75): left_data
//      slot4 (n 76..95): right_data
//      n 96..255: zero
//  - Alignment: in the cycle where bit_count==n, sdata_out = frame bit n and sync = (n<16); both outputs are registered.
//  - ready=1 only in cycles with bit_count==255; it is never high during reset or in the first post-reset cycle. Latency from ready to the latch edge is 0, so upstream sees ready and may update its outputs for the following frame.
//  - Input capture: sdata_in registered at the end of the cycle with bit_count==n is input frame bit n, shifted into a 256-bit in register.
//  - At the 255->0 edge the status outputs update from the just-completed input frame:
//      codec_ready <= in_tag[15]
//      status_data, left_in_data, right_in_data load only if their tag bit is set; otherwise they hold.
//  - Simultaneous events: the latch and the input-frame update occur on the same edge; both are independent.
//  - Reset mid-frame: the frame is abandoned, all outputs return to reset values, and the next frame starts cleanly from n=0 after release.
//  - Invalid inputs (valid=0): the corresponding tag bit is 0; data bits are still shifted out unchanged.
// STRUCTURE
//  - Package ac97_pkg holds:
//      FRAME_BITS, TAG_BITS, SLOT_BITS
//      slot bit offsets (SLOT1_OFS=16 .. SLOT4_OFS=76)
//      tag bit positions (TAG_FRAME=15, TAG_CMD_A=14, TAG_CMD_D=13, TAG_LEFT=12, TAG_RIGHT=11)
//  - Sub-module ac97_frame_timer: bit_count, sync, ready.
//  - Shift/capture logic stays in the top.
// TESTING
//  1. Hold reset 3 cycles, then release -> sync high for cycles 0..15 and low for 16..255; ready high only at n=255; period is 256 cycles.
//  2. cmd 80_0000 valid, left=20'hABCDE, right=20'h12345, both valid -> tag 16'hF800; slot1 20'h80000; slot2 0; slot3 ABCDE; slot4 12345.
//  3. cmd 04_0A0A, command_valid=0, PCM valid=0 -> tag 16'h8000; slot1 20'h04000 and slot2 20'h0A0A0 still shifted out.
//  4. Codec model drives tag 16'hF800, slot2=20'h12340, slot3=20'hFFFFF -> after 255->0 edge: codec_ready=1, status_data=16'h1234, left_in_data=FFFFF. A next frame with tag 16'h8000 leaves left_in_data held.
//  5. Assert reset at n=100 for 1 cycle -> outputs cleared; after release sync rises on the first cycle and a fresh latch occurs.
//  6. Feed ready into ac97commands -> decoded slot1/slot2 sequence 80_0000, 80_0000, ..., 04_vol, ..., 18_0808 in frame order.

Source files
------------

// File: rtl/ac97_pkg.sv
// ---------------------------------------------------------------------------
// ac97_pkg
// Shared constants and helpers for the AC'97 link framer.
//   - Frame geometry: FRAME_BITS, TAG_BITS, SLOT_BITS and slot bit offsets.
//   - Tag bit positions within slot 0.
//   - build_out_frame(): assembles one outgoing 256-bit frame.
// Frame bit n (n=0 is the first bit on the wire) is stored at vector index
// FRAME_BITS-1-n, so a frame vector shifts out MSB first.
// ---------------------------------------------------------------------------
package ac97_pkg;

    localparam int FRAME_BITS = 256;
    localparam int TAG_BITS   = 16;
    localparam int SLOT_BITS  = 20;

    localparam int SLOT1_OFS  = 16;
    localparam int SLOT2_OFS  = 36;
    localparam int SLOT3_OFS  = 56;
    localparam int SLOT4_OFS  = 76;

    localparam int TAG_FRAME  = 15;
    localparam int TAG_CMD_A  = 14;
    localparam int TAG_CMD_D  = 13;
    localparam int TAG_LEFT   = 12;
    localparam int TAG_RIGHT  = 11;

    localparam logic [7:0] BIT_LAST  = 8'd255;
    localparam logic [7:0] SYNC_BITS = 8'd16;

    typedef logic [FRAME_BITS-1:0] frame_t;
    typedef logic [SLOT_BITS-1:0]  slot_t;

    // Outgoing frame: tag, command address/data, PCM pair, remaining slots zero.
    // Data bits go out regardless of their valid flag; only the tag reflects validity.
    function automatic frame_t build_out_frame(
        input logic        cmd_v,
        input logic        left_v,
        input logic        right_v,
        input logic [7:0]  addr,
        input logic [15:0] data,
        input slot_t       left,
        input slot_t       right
    );
        frame_t                f;
        logic [TAG_BITS-1:0]   tag;
        tag            = {TAG_BITS{1'b0}};
        tag[TAG_FRAME] = 1'b1;
        tag[TAG_CMD_A] = cmd_v;
        tag[TAG_CMD_D] = cmd_v;
        tag[TAG_LEFT]  = left_v;
        tag[TAG_RIGHT] = right_v;
        f = {FRAME_BITS{1'b0}};
        f[FRAME_BITS-1 -: TAG_BITS]              = tag;
        f[FRAME_BITS-1-SLOT1_OFS -: SLOT_BITS]   = {addr, 12'h000};
        f[FRAME_BITS-1-SLOT2_OFS -: SLOT_BITS]   = {data, 4'h0};
        f[FRAME_BITS-1-SLOT3_OFS -: SLOT_BITS]   = left;
        f[FRAME_BITS-1-SLOT4_OFS -: SLOT_BITS]   = right;
        return f;
    endfunction

endpackage

// File: rtl/ac97_frame_timer.sv
// ---------------------------------------------------------------------------
// ac97_frame_timer
// Free-running 8-bit bit counter for the AC'97 frame, plus registered SYNC
// and the one-cycle ready strobe.
// Ports:
//   i_clk        in   bit clock
//   i_reset      in   synchronous active-high reset (counter parks at 255)
//   o_sync       out  high while the current bit is in the tag slot (n<16)
//   o_ready      out  high in the cycle with bit_count==255 (never right after reset)
//   o_frame_end  out  combinational: current bit_count==255, next edge is the frame latch
// ---------------------------------------------------------------------------
module ac97_frame_timer
    import ac97_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    output logic o_sync,
    output logic o_ready,
    output logic o_frame_end
);

    logic [7:0] r_bit_count;
    logic [7:0] w_next_count;
    logic       r_sync;
    logic       r_ready;

    // 8-bit arithmetic wraps 255->0 on its own; there is no idle state.
    assign w_next_count = r_bit_count + 8'd1;

    // Bit counter and the registered sync/ready decoded from the next count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bit_count <= BIT_LAST;
            r_sync      <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_bit_count <= w_next_count;
            r_sync      <= (w_next_count < SYNC_BITS);
            r_ready     <= (w_next_count == BIT_LAST);
        end
    end

    assign o_sync      = r_sync;
    assign o_ready     = r_ready;
    assign o_frame_end = (r_bit_count == BIT_LAST);

endmodule

// File: rtl/ac97_link_frame.sv
// ---------------------------------------------------------------------------
// ac97_link_frame
// AC'97 link framer: latches one register command and one PCM sample pair per
// 256-bit frame, serialises them on sdata_out with sync, deserialises the
// codec's sdata_in frame and publishes its status/PCM slots.
// Ports:
//   clock, reset                     bit clock, synchronous active-high reset
//   ready                            frame strobe (bit_count==255)
//   command_address/data/valid       register command for slots 1/2
//   left_data/valid, right_data/valid playback samples for slots 3/4
//   sync, sdata_out                  outgoing link, MSB first
//   sdata_in                         incoming link
//   codec_ready                      input tag[15] of last completed frame
//   status_data                      input slot2[19:4], last frame with tag[13]
//   left_in_data, right_in_data      input slots 3/4, last frame with tag[12]/[11]
// ---------------------------------------------------------------------------
module ac97_link_frame
    import ac97_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic        ready,
    input  logic [7:0]  command_address,
    input  logic [15:0] command_data,
    input  logic        command_valid,
    input  logic [19:0] left_data,
    input  logic        left_valid,
    input  logic [19:0] right_data,
    input  logic        right_valid,
    output logic        sync,
    output logic        sdata_out,
    input  logic        sdata_in,
    output logic        codec_ready,
    output logic [15:0] status_data,
    output logic [19:0] left_in_data,
    output logic [19:0] right_in_data
);

    logic                  w_frame_end;
    frame_t                w_out_frame;
    frame_t                w_in_frame;
    logic                  w_unused_in;

    // Bit 0 of a frame goes straight into r_sdata_out at the latch edge,
    // so the shifter only has to hold the remaining 255 bits.
    logic [FRAME_BITS-2:0] r_out_shift;
    logic                  r_sdata_out;
    logic [FRAME_BITS-2:0] r_in_shift;
    logic                  r_codec_ready;
    logic [15:0]           r_status_data;
    logic [19:0]           r_left_in_data;
    logic [19:0]           r_right_in_data;

    ac97_frame_timer u_timer (
        .i_clk       (clock),
        .i_reset     (reset),
        .o_sync      (sync),
        .o_ready     (ready),
        .o_frame_end (w_frame_end)
    );

    assign w_out_frame = build_out_frame(command_valid, left_valid, right_valid,
                                         command_address, command_data,
                                         left_data, right_data);

    // The bit being sampled at the latch edge is bit 255 of the input frame,
    // so the completed frame is the shifter plus the live sdata_in.
    assign w_in_frame  = {r_in_shift, sdata_in};

    // Slot 1, the low status nibble and slots 5..12 are not published.
    assign w_unused_in = ^w_in_frame;

    // Outgoing shifter, incoming shifter and frame-boundary status update.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_shift     <= {(FRAME_BITS-1){1'b0}};
            r_sdata_out     <= 1'b0;
            r_in_shift      <= {(FRAME_BITS-1){1'b0}};
            r_codec_ready   <= 1'b0;
            r_status_data   <= 16'h0000;
            r_left_in_data  <= 20'h00000;
            r_right_in_data <= 20'h00000;
        end else begin
            r_in_shift <= w_in_frame[FRAME_BITS-2:0];
            if (w_frame_end) begin
                r_sdata_out   <= w_out_frame[FRAME_BITS-1];
                r_out_shift   <= w_out_frame[FRAME_BITS-2:0];
                r_codec_ready <= w_in_frame[FRAME_BITS-TAG_BITS+TAG_FRAME];
                if (w_in_frame[FRAME_BITS-TAG_BITS+TAG_CMD_D]) begin
                    r_status_data <= w_in_frame[FRAME_BITS-1-SLOT2_OFS -: 16];
                end else begin
                    r_status_data <= r_status_data;
                end
                if (w_in_frame[FRAME_BITS-TAG_BITS+TAG_LEFT]) begin
                    r_left_in_data <= w_in_frame[FRAME_BITS-1-SLOT3_OFS -: SLOT_BITS];
                end else begin
                    r_left_in_data <= r_left_in_data;
                end
                if (w_in_frame[FRAME_BITS-TAG_BITS+TAG_RIGHT]) begin
                    r_right_in_data <= w_in_frame[FRAME_BITS-1-SLOT4_OFS -: SLOT_BITS];
                end else begin
                    r_right_in_data <= r_right_in_data;
                end
            end else begin
                r_sdata_out <= r_out_shift[FRAME_BITS-2];
                r_out_shift <= {r_out_shift[FRAME_BITS-3:0], 1'b0};
            end
        end
    end

    assign sdata_out     = r_sdata_out;
    assign codec_ready   = r_codec_ready;
    assign status_data   = r_status_data;
    assign left_in_data  = r_left_in_data;
    assign right_in_data = r_right_in_data;

endmodule
